// File: rtl/dds_pkg.sv
// Shared widths, constants and helpers for the sine DDS tone source.
package dds_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 11;
    localparam int DIV_W_DEF   = 16;

    // Quadrant codes taken from the top two table-address bits
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Offset-binary midpoint for a dw-bit sample
    function automatic int dds_mid(input int dw);
        return 1 << (dw - 1);
    endfunction

    // Phase increment giving f_out at one tick per sample at rate f_tick
    function automatic longint dds_tune_word(input real f_out, input real f_tick, input int phase_w);
        return longint'($rtoi(f_out / f_tick * (2.0 ** phase_w) + 0.5));
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude ROM, contents built at elaboration time.
// Synchronous read: the address is registered and the data follows it.
module quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [ADDR_W-3:0] i_addr,
    output logic [DATA_W-2:0] o_data
);

    localparam int Q   = 2 ** (ADDR_W - 2);
    localparam int MID = dds_mid(DATA_W);

    // Half-step sample points keep the folded wave free of duplicate peaks at zero
    function automatic logic [DATA_W-2:0] rom_val(input int i);
        real x;
        int  v;
        x = real'(MID - 1) * $sin(3.14159265358979 * (real'(i) + 0.5) / real'(2 * Q));
        v = $rtoi(x + 0.5);
        return v[DATA_W-2:0];
    endfunction

    logic [DATA_W-2:0] w_rom [Q];
    logic [ADDR_W-3:0] r_addr;

    generate
        for (genvar g = 0; g < Q; g++) begin : g_rom
            localparam logic [DATA_W-2:0] VAL = rom_val(g);
            assign w_rom[g] = VAL;
        end
    endgenerate

    // Capture the lookup address only when a new sample is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_addr <= '0;
        else if (i_en) r_addr <= i_addr;
    end

    assign o_data = w_rom[r_addr];

endmodule

// File: rtl/sine_dds.sv
// Direct-digital-synthesis sine source: divider, phase accumulator,
// quarter-wave folded lookup, two-stage registered output.
// Optional PWM output stage enabled by defining SINE_DDS_PWM_EN.
module sine_dds
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [PHASE_W-1:0] i_tune_word,
    input  logic               i_tune_load,
    input  logic [DIV_W-1:0]   i_sample_div,
    output logic [DATA_W-1:0]  o_sample,
    output logic               o_sample_valid,
    output logic               o_phase_wrap,
    output logic               o_pwm_out
);

    localparam logic [DATA_W-1:0] MID_V = DATA_W'(dds_mid(DATA_W));

    logic [DIV_W-1:0]   r_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_tune;
    logic               r_wrap;
    logic [1:0]         r_quad;
    logic [1:0]         r_vld_pipe;
    logic [DATA_W-1:0]  r_sample;

    logic               w_tick;
    logic [PHASE_W:0]   w_sum;
    logic [ADDR_W-1:0]  w_addr;
    logic [1:0]         w_quad;
    logic [ADDR_W-3:0]  w_idx;
    logic [DATA_W-2:0]  w_mag;

    // >= rather than == so a lowered divisor ticks at once instead of wrapping
    assign w_tick = i_enable && (r_cnt >= i_sample_div);
    assign w_sum  = {1'b0, r_phase} + {1'b0, r_tune};
    assign w_addr = r_phase[PHASE_W-1 -: ADDR_W];
    assign w_quad = w_addr[ADDR_W-1 -: 2];
    assign w_idx  = (w_quad == Q1 || w_quad == Q3) ? ~w_addr[ADDR_W-3:0] : w_addr[ADDR_W-3:0];

    quarter_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_tick),
        .i_addr (w_idx),
        .o_data (w_mag)
    );

    // Sample-rate divider; frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_cnt <= '0;
        else if (i_enable) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end

    // Tune register; a coincident tick still sees the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_tune <= '0;
        else if (i_tune_load) r_tune <= i_tune_word;
    end

    // Phase accumulator and registered carry strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_tick & w_sum[PHASE_W];
            if (w_tick) r_phase <= w_sum[PHASE_W-1:0];
        end
    end

    // Stage 1: quadrant travels alongside the ROM address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quad     <= Q0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_tick};
            if (w_tick) r_quad <= w_quad;
        end
    end

    // Stage 2: fold magnitude around MID; lower half mirrored as MID-1-m
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_sample <= MID_V;
        else if (r_vld_pipe[0]) r_sample <= (r_quad == Q2 || r_quad == Q3)
                                            ? MID_V - 1'b1 - {1'b0, w_mag}
                                            : MID_V + {1'b0, w_mag};
    end

    assign o_sample       = r_sample;
    assign o_sample_valid = r_vld_pipe[1];
    assign o_phase_wrap   = r_wrap;

`ifdef SINE_DDS_PWM_EN
    logic [DATA_W-1:0] r_pwm_cnt;
    logic              r_pwm;

    // Free-running PWM carrier and comparator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pwm     <= (r_pwm_cnt < r_sample);
        end
    end

    assign o_pwm_out = r_pwm;
`else
    assign o_pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_sine_dds.sv
// Self-checking bench for sine_dds: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_sine_dds;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        tune_load = 1'b0;
    logic [23:0] tune_word = '0;
    logic [15:0] sample_div = '0;
    logic [10:0] o_sample;
    logic        o_sample_valid, o_phase_wrap, o_pwm_out;

    int n_vec = 0;
    int n_err = 0;

    sine_dds dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .i_tune_word    (tune_word),
        .i_tune_load    (tune_load),
        .i_sample_div   (sample_div),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_phase_wrap   (o_phase_wrap),
        .o_pwm_out      (o_pwm_out)
    );

    always #5 clk = ~clk;

    // Expected sample for an 8-bit table address, from the folding rules
    function automatic logic [10:0] ref_sample(input int addr);
        int qd, i, m;
        real x;
        qd = (addr >> 6) & 3;
        i  = addr & 63;
        if (qd == 1 || qd == 3) i = 63 - i;
        x = 1023.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0);
        m = $rtoi(x + 0.5);
        return (qd < 2) ? 11'(1024 + m) : 11'(1023 - m);
    endfunction

    // Behavioural model: pending samples scheduled by edge number
    typedef struct { longint due; logic [10:0] val; } pend_t;
    pend_t       q[$];
    longint      cyc = 0;
    longint      m_phase, m_tune, m_cnt, sum;
    logic [10:0] m_sample = 11'd1024;
    logic        m_valid = 1'b0, m_wrap = 1'b0;
    bit          tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_phase = 0; m_tune = 0; m_cnt = 0;
            m_sample = 11'd1024; m_valid = 1'b0; m_wrap = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_sample = q[0].val;
                m_valid  = 1'b1;
                void'(q.pop_front());
            end
            tk = enable && (m_cnt >= longint'(sample_div));
            if (tk) begin
                q.push_back('{cyc + 1, ref_sample(int'(m_phase >> 16))});
                sum     = m_phase + m_tune;
                m_wrap  = (sum >= 64'd16777216);
                m_phase = sum % 64'd16777216;
            end
            if (enable) m_cnt = tk ? 0 : m_cnt + 1;
            if (tune_load) m_tune = longint'(tune_word);
        end
        cyc++;
    end

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0; tune_load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_tune(input logic [23:0] w);
        tune_word = w; tune_load = 1'b1;
        @(negedge clk);
        tune_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; tune_word = 24'h0F0000; tune_load = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (o_sample !== 11'd1024 || o_sample_valid !== 1'b0 || o_phase_wrap !== 1'b0 || o_pwm_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: sample=%0d valid=%b wrap=%b pwm=%b, want 1024/0/0/0",
                     o_sample, o_sample_valid, o_phase_wrap, o_pwm_out);
        end
        enable = 1'b0; tune_load = 1'b0; tune_word = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unit_step();
        logic [10:0] s[512];
        int wraps = 0;
        apply_reset();
        sample_div = 16'd0;
        load_tune(24'd65536);
        enable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_sample_valid !== 1'b0) begin
            n_err++; $display("FAIL latency_early: valid=%b want 0", o_sample_valid);
        end
        @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            n_vec++;
            if (o_sample_valid !== 1'b1 || o_sample !== ref_sample(k % 256)) begin
                n_err++;
                $display("FAIL unit_step[%0d]: valid=%b sample=%0d want 1/%0d", k, o_sample_valid, o_sample, ref_sample(k % 256));
            end
            s[k] = o_sample;
            if (o_phase_wrap) wraps++;
            @(negedge clk);
        end
        enable = 1'b0;
        n_vec++;
        if (wraps != 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", wraps); end
        n_vec++;
        if (s[0] !== 11'd1037 || s[128] !== 11'd1010) begin
            n_err++; $display("FAIL endpoints: a0=%0d a128=%0d want 1037/1010", s[0], s[128]);
        end
        n_vec++;
        if (s[63] !== s[64] || s[191] !== s[192]) begin
            n_err++; $display("FAIL peak_fold: a63=%0d a64=%0d a191=%0d a192=%0d", s[63], s[64], s[191], s[192]);
        end
        for (int a = 0; a < 128; a++) begin
            n_vec++;
            if (int'(s[a]) + int'(s[a + 128]) != 2047) begin
                n_err++; $display("FAIL antisym[%0d]: %0d + %0d want sum 2047", a, s[a], s[a + 128]);
            end
        end
    endtask

    task automatic test_rate();
        int gap, k;
        apply_reset();
        sample_div = 16'd1492;
        load_tune(24'd65536);
        enable = 1'b1;
        for (int t = 0; t < 3000 && !o_sample_valid; t++) @(negedge clk);
        n_vec++;
        if (!o_sample_valid) begin n_err++; $display("FAIL rate_first: no strobe within 3000 cycles"); end
        k = 1;
        repeat (4) begin
            gap = 0;
            do begin @(negedge clk); gap++; end while (!o_sample_valid && gap < 3000);
            n_vec++;
            if (gap != 1493 || o_sample !== ref_sample(k)) begin
                n_err++; $display("FAIL rate_gap: gap=%0d sample=%0d want 1493/%0d", gap, o_sample, ref_sample(k));
            end
            k++;
        end
        enable = 1'b0;
    endtask

    task automatic test_retune();
        int want[4] = '{1, 2, 7, 12};
        int t;
        apply_reset();
        sample_div = 16'd3;
        load_tune(24'h010000);
        enable = 1'b1;
        for (t = 0; t < 100 && !o_sample_valid; t++) @(negedge clk);
        n_vec++;
        if (!o_sample_valid || o_sample !== ref_sample(0)) begin
            n_err++; $display("FAIL retune_first: valid=%b sample=%0d want 1/%0d", o_sample_valid, o_sample, ref_sample(0));
        end
        // next tick falls in the cycle after two more edges
        repeat (2) @(negedge clk);
        load_tune(24'h050000);
        for (int n = 0; n < 4; n++) begin
            t = 0;
            while (!o_sample_valid && t < 100) begin @(negedge clk); t++; end
            n_vec++;
            if (!o_sample_valid || o_sample !== ref_sample(want[n])) begin
                n_err++; $display("FAIL retune[%0d]: sample=%0d want %0d", n, o_sample, ref_sample(want[n]));
            end
            @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_hold();
        int k = 0, late = 0;
        apply_reset();
        sample_div = 16'd0;
        load_tune(24'd65536);
        enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 20) enable = 1'b0;
            if (c == 32) enable = 1'b1;
            @(negedge clk);
            if (o_sample_valid) begin
                n_vec++;
                if (o_sample !== ref_sample(k % 256)) begin
                    n_err++; $display("FAIL hold_seq[%0d]: sample=%0d want %0d", k, o_sample, ref_sample(k % 256));
                end
                k++;
                if (c >= 20 && c < 32) late++;
            end
        end
        enable = 1'b0;
        n_vec++;
        if (late != 1) begin n_err++; $display("FAIL hold_drain: %0d strobes after hold, want 1", late); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            r = $urandom;
            enable    = (r[2:0] != 3'd0);
            tune_load = (r[7:4] == 4'd0);
            if (r[11:8] == 4'd0) sample_div = 16'($urandom_range(0, 5));
            r = $urandom;
            tune_word = r[23:0];
            @(negedge clk);
            n_vec++;
            if (o_sample_valid !== m_valid || o_sample !== m_sample || o_phase_wrap !== m_wrap) begin
                n_err++;
                $display("FAIL random[%0d]: valid=%b sample=%0d wrap=%b want %b/%0d/%b",
                         c, o_sample_valid, o_sample, o_phase_wrap, m_valid, m_sample, m_wrap);
            end
        end
        enable = 1'b0; tune_load = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        sample_div = 16'd0;
        load_tune(24'h123456);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (o_sample_valid !== 1'b1) begin n_err++; $display("FAIL async_pre: valid=%b want 1", o_sample_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_sample !== 11'd1024 || o_sample_valid !== 1'b0 || o_phase_wrap !== 1'b0 || o_pwm_out !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: sample=%0d valid=%b wrap=%b pwm=%b, want 1024/0/0/0",
                     o_sample, o_sample_valid, o_phase_wrap, o_pwm_out);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (o_sample_valid !== 1'b0 || o_sample !== 11'd1024) begin
            n_err++; $display("FAIL async_flush: valid=%b sample=%0d want 0/1024", o_sample_valid, o_sample);
        end
    endtask

`ifdef SINE_DDS_PWM_EN
    task automatic test_pwm();
        int hi = 0;
        apply_reset();
        @(negedge clk);
        repeat (2048) begin @(negedge clk); if (o_pwm_out) hi++; end
        n_vec++;
        if (hi != 1024) begin n_err++; $display("FAIL pwm_mid: high %0d of 2048 want 1024", hi); end
        // one tick moves phase to address 191, then freeze it there
        sample_div = 16'd0;
        load_tune(24'(191 * 65536));
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        load_tune(24'd0);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        n_vec++;
        if (o_sample !== 11'd0) begin n_err++; $display("FAIL pwm_zero_setup: sample=%0d want 0", o_sample); end
        hi = 0;
        repeat (2) @(negedge clk);
        repeat (2048) begin @(negedge clk); if (o_pwm_out) hi++; end
        n_vec++;
        if (hi != 0) begin n_err++; $display("FAIL pwm_zero: high %0d of 2048 want 0", hi); end
    endtask
`endif

    initial begin
        test_reset();
        test_unit_step();
        test_rate();
        test_retune();
        test_hold();
        test_random();
        test_async_reset();
`ifdef SINE_DDS_PWM_EN
        test_pwm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sine_dds.md
Name: sine_dds

Overview:
- Parametrised direct-digital-synthesis tone source.
- Replaces fixed address stepping into a quarter-sine BRAM with:
  - a programmable phase accumulator,
  - a sample-rate divider,
  - quarter-wave symmetry folding,
  - a pipelined registered lookup.
- Drives the PWM audio path with offset-binary samples at any pitch.
- Sits between control logic (note selection) and the PWM output stage.

Parameters:
- PHASE_W, 24, phase accumulator width.
- ADDR_W, 8, full-wave table address bits. Quarter ROM depth is Q = 2^(ADDR_W-2).
- DATA_W, 11, output sample width, offset binary.
- DIV_W, 16, sample-rate divider width.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run/hold.
- tune_word  in  PHASE_W  phase increment per sample.
- tune_load  in  1  capture tune_word.
- sample_div  in  DIV_W  tick every sample_div+1 cycles.
- sample  out  DATA_W  current sample.
- sample_valid  out  1  one-cycle strobe when sample is updated.
- phase_wrap  out  1  one-cycle strobe on accumulator overflow.
- pwm_out  out  1  PWM of sample (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - phase=0, tune register=0, divider count=0, pipeline valid bits cleared.
  - sample=MID=2^(DATA_W-1), sample_valid=0, phase_wrap=0, pwm_out=0.
  - Reset mid-pipeline discards in-flight samples.
- Divider:
  - Counts while enable=1.
  - tick asserts when count >= sample_div; count then returns to 0, otherwise it increments.
  - sample_div=0 gives a tick every cycle.
  - Lowering sample_div below the current count gives a tick on the next enabled cycle.
- Tune register:
  - Loads tune_word when tune_load=1.
  - A tick in the same cycle uses the old value.
- Accumulator on tick:
  - phase <= phase + tune (mod 2^PHASE_W).
  - The sample for that tick is computed from the pre-increment phase, so the first sample after reset is phase 0.
  - A carry out pulses phase_wrap in the following cycle.
- Lookup (stage 1, registered):
  - a = phase[PHASE_W-1 -: ADDR_W]; quadrant = a[ADDR_W-1:ADDR_W-2]; idx = a[ADDR_W-3:0].
  - Quadrants 1 and 3 use ~idx.
  - m = rom[idx], where rom[i] = round((MID-1)*sin(pi/2*(i+0.5)/Q)).
- Fold (stage 2, registered):
  - Quadrants 0 and 1: sample = MID + m.
  - Quadrants 2 and 3: sample = MID - 1 - m.
  - Range 0..2^DATA_W-1 with no overflow; the waveform is exactly antisymmetric.
- Latency: sample and sample_valid update on the 2nd rising edge after the tick cycle. sample holds between strobes.
- enable=0:
  - Divider and phase freeze.
  - In-flight samples still emerge, then no further strobes.
  - Re-enable resumes from the frozen count and phase.
- tune_word=0 gives a constant sample with strobes still produced.

Optional Feature:
- Macro SINE_DDS_PWM_EN.
- Defined:
  - Free-running DATA_W-bit counter.
  - pwm_out registered as (counter < sample); duty = sample/2^DATA_W.
  - Counter resets to 0.
- Undefined: pwm_out tied 0 and the counter is not built.

Decomposition:
- Package dds_pkg holds:
  - default widths,
  - the MID constant function,
  - quadrant localparams (Q0..Q3),
  - a helper computing tune words from (f_out, f_clk, PHASE_W) for benches.
- One sub-module, quarter_sine_rom:
  - Q x (DATA_W-1) synchronous-read ROM with a registered address.
  - Initialised via $readmemh file or generate-time function.

Test Plan:
1. Reset:
   - Hold rst_n=0 -> sample=1024, sample_valid=0, phase_wrap=0, pwm_out=0.
   - Assert rst_n asynchronously mid-stream -> same values immediately, without waiting for a clock edge.
2. Unit step:
   - tune_word=65536, sample_div=0, enable=1 -> sample_valid every cycle starting 2 cycles after the first tick.
   - One phase_wrap per 256 samples.
   - Address 0 gives 1024+rom[0]; address 63 equals address 64; address 128 gives 1023-rom[0].
3. Rate:
   - sample_div=1492, tune_word=65536 -> strobes exactly 1493 cycles apart.
   - Period 256 samples, approx 261.6 Hz.
4. Retune race:
   - tune_load coincident with tick -> that increment uses the old word; the next tick uses the new word.
5. Hold:
   - Drop enable mid-stream -> pending samples (at most 2) still strobe, then silence.
   - Re-enable -> phase continues contiguous with no skipped or repeated address.
6. PWM (SINE_DDS_PWM_EN defined):
   - Constant sample 1024 -> pwm_out high 1024 of every 2048 cycles.
   - Sample 0 -> pwm_out always 0.
